// File: rtl/signed_display_if.sv
// Handshake and display bus between a value producer and signed_display_ctrl.
interface signed_display_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic       done;
  logic [1:0] en;
  logic [3:0] num;

  modport master (
    output value, load,
    input  busy, done, en, num
  );

  modport slave (
    input  value, load,
    output busy, done, en, num
  );
endinterface

// File: rtl/signed_display_ctrl.sv
// Signed 8-bit to four-digit seven-segment display controller: double-dabble
// conversion with zero suppression, plus a free-running digit refresh scan.
module signed_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  signed_display_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [3:0]  CODE_MINUS = 4'd10;
  localparam logic [3:0]  CODE_BLANK = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sign;
  logic [7:0]       r_mag;
  logic [11:0]      r_bcd;
  logic [2:0]       r_bit;
  logic             r_done;
  logic [3:0]       r_digit [4];
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_en;
  logic [7:0]       w_mag;
  logic [11:0]      w_adj;

  // -128 negates to 8'h80, which is exactly 128 as an unsigned magnitude
  assign w_mag = bus.value[7] ? (~bus.value + 8'd1) : bus.value;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.load) w_next = S_CONVERT;
      S_CONVERT: if (r_bit == 3'd7) w_next = S_UPDATE;
      S_UPDATE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_bit      <= '0;
      r_done     <= 1'b0;
      r_digit[3] <= CODE_BLANK;
      r_digit[2] <= CODE_BLANK;
      r_digit[1] <= CODE_BLANK;
      r_digit[0] <= 4'd0;
    end else begin
      r_done <= (r_state == S_UPDATE);
      case (r_state)
        S_IDLE: begin
          if (bus.load) begin
            r_sign <= bus.value[7];
            r_mag  <= w_mag;
            r_bcd  <= '0;
            r_bit  <= '0;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_mag} <= {w_adj[10:0], r_mag, 1'b0};
          r_bit          <= r_bit + 3'd1;
        end
        S_UPDATE: begin
          // All four digits commit together so no partial result is ever shown
          r_digit[3] <= r_sign ? CODE_MINUS : CODE_BLANK;
          r_digit[2] <= (r_bcd[11:8] == 4'd0) ? CODE_BLANK : r_bcd[11:8];
          r_digit[1] <= (r_bcd[11:4] == 8'd0) ? CODE_BLANK : r_bcd[7:4];
          r_digit[0] <= r_bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_en  <= '0;
    end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_en  <= r_en + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.en   = r_en;
  assign bus.num  = r_digit[r_en];

endmodule
